// File: rtl/hilo_muldiv.sv
`timescale 1ns/1ps
// Multiply/divide unit with HI/LO registers for the MIPS execute stage.
// Single-cycle multiply, radix-2 restoring divide with sign fix-up cycle.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int W2 = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] opa_q, opa_d;   // raw a_i: multiplicand, or dividend for div-by-zero
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplier or divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend bits shift out as quotient bits shift in
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dbz_q, dbz_d;
  logic             stall_c, done_c;

  logic [W2-1:0]    mul_a_ext, mul_b_ext, product;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             a_neg, b_neg;

  assign mul_a_ext = {{WIDTH{sgn_q & opa_q[WIDTH-1]}}, opa_q};
  assign mul_b_ext = {{WIDTH{sgn_q & opb_q[WIDTH-1]}}, opb_q};
  assign product   = mul_a_ext * mul_b_ext;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, opb_q};
  assign q_fix   = qneg_q ? (WIDTH'(0) - quo_q) : quo_q;
  assign r_fix   = rneg_q ? (WIDTH'(0) - rem_q) : rem_q;

  assign a_neg = (op_i == OP_DIV) & a_i[WIDTH-1];
  assign b_neg = (op_i == OP_DIV) & b_i[WIDTH-1];

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    stall_c = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_i && !flush_i) begin
          case (op_i)
            OP_MTHI: hi_d = a_i;
            OP_MTLO: lo_d = a_i;
            OP_MULT, OP_MULTU: begin
              stall_c = 1'b1;
              opa_d   = a_i;
              opb_d   = b_i;
              sgn_d   = (op_i == OP_MULT);
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              stall_c = 1'b1;
              opa_d   = a_i;
              quo_d   = a_neg ? (WIDTH'(0) - a_i) : a_i;
              opb_d   = b_neg ? (WIDTH'(0) - b_i) : b_i;
              qneg_d  = a_neg ^ b_neg;
              rneg_d  = a_neg;
              dbz_d   = (b_i == '0);
              rem_d   = '0;
              cnt_d   = '0;
              state_d = S_DIV;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        state_d = S_IDLE;
        if (!flush_i) begin
          {hi_d, lo_d} = product;
          done_c       = 1'b1;
        end
      end
      S_DIV: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          stall_c = 1'b1;
          // A clear top bit of the difference means the trial subtraction fits.
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (!flush_i) begin
          done_c = 1'b1;
          hi_d   = dbz_q ? opa_q : r_fix;
          lo_d   = dbz_q ? '1 : q_fix;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
    end
  end

  // Reset must drop the stall immediately even if a valid op is still presented.
  assign stall_o = stall_c & resetn;
  assign done_o  = done_c & resetn;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule
